// File: rtl/gray_count_decoder_if.sv
// ---------------------------------------------------------------------------
// gray_count_decoder_if
//   Bundles the tracking-side signals of gray_count_decoder.
//   master : the side that supplies the gray word and control (LO side / TB)
//   slave  : the decoder itself
//   Signals:
//     en         tracking enable
//     gray_in    gray count from the LO counter (asynchronous to clk)
//     clr_err    single-cycle pulse that clears err_sticky
//     bin_out    registered binary phase
//     step       one-cycle pulse on a +1 advance
//     wrap       one-cycle pulse on the all-ones -> 0 advance
//     wrap_cnt   wraps since PRIME, modulo 2^WRAP_W
//     step_err   one-cycle pulse on an illegal change
//     err_sticky latched error flag
// ---------------------------------------------------------------------------
interface gray_count_decoder_if #(
    parameter int WIDTH  = 8,
    parameter int WRAP_W = 16
);
    logic              en;
    logic [WIDTH-1:0]  gray_in;
    logic              clr_err;
    logic [WIDTH-1:0]  bin_out;
    logic              step;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              step_err;
    logic              err_sticky;

    modport master (
        output en, gray_in, clr_err,
        input  bin_out, step, wrap, wrap_cnt, step_err, err_sticky
    );

    modport slave (
        input  en, gray_in, clr_err,
        output bin_out, step, wrap, wrap_cnt, step_err, err_sticky
    );
endinterface

// File: rtl/gray_count_decoder.sv
// ---------------------------------------------------------------------------
// gray_count_decoder
//   Receive-side companion to the LO gray-code phase counter. The gray word
//   is brought into the clk domain through a SYNC_STAGES-deep synchronizer,
//   converted to binary, and every change is checked for being a single +1
//   advance. Full-cycle wraps (all-ones -> 0) are counted.
//
//   Parameters:
//     WIDTH        gray/binary word width
//     SYNC_STAGES  synchronizer depth, 2 or 3
//     WRAP_W       wrap counter width
//   Ports:
//     clk  local sampling clock, rising edge
//     rst  asynchronous active-high reset
//     bus  gray_count_decoder_if.slave (en, gray_in, clr_err in;
//          bin_out, step, wrap, wrap_cnt, step_err, err_sticky out)
//
//   Build option:
//     GRAY_DEC_ERR_EN  defined   : illegal-step detection (step_err,
//                                  err_sticky, clr_err) is compiled in.
//                      undefined : every nonzero change is taken as a step,
//                                  wrap fires when the new value is below the
//                                  old one, error outputs stay 0.
// ---------------------------------------------------------------------------
module gray_count_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_W      = 16
) (
    input  logic clk,
    input  logic rst,
    gray_count_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizer
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gs;

    // NOTE: the synchronizer chain is reset along with everything else, so
    // the first word seen after reset is a defined 0 rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Gray -> binary: bit i is the XOR of all gray bits at i and above.
    // Written as a reduction per bit so there is no bit-to-bit chain inside
    // one vector.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] delta;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) b[i] = ^(gs >> i);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              step_err_q, step_err_d;
    logic              sticky_q, sticky_d;

    // Modulo-2^WIDTH distance from the current phase to the new sample.
    assign delta = b - bin_q;

    // NOTE: every variable gets its default before the case statement, so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        step_err_d = 1'b0;
        sticky_d   = sticky_q;

`ifdef GRAY_DEC_ERR_EN
        // A set further down overrides this clear.
        if (bus.clr_err) sticky_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.en) state_d = PRIME;
            end

            PRIME: begin
                // First sample is taken as-is; it is never an error.
                bin_d      = b;
                wrap_cnt_d = '0;
                state_d    = TRACK;
            end

            TRACK: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (delta != '0) begin
                    // Legal or not, resynchronize to the new value.
                    bin_d = b;
`ifdef GRAY_DEC_ERR_EN
                    if (delta == WIDTH'(1)) begin
                        step_d = 1'b1;
                        if (bin_q == {WIDTH{1'b1}}) begin
                            wrap_d     = 1'b1;
                            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                        end
                    end else begin
                        step_err_d = 1'b1;
                        sticky_d   = 1'b1;
                    end
`else
                    step_d = 1'b1;
                    if (b < bin_q) begin
                        wrap_d     = 1'b1;
                        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                    end
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
            step_err_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
            step_err_q <= step_err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.step       = step_q;
    assign bus.wrap       = wrap_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
`ifdef GRAY_DEC_ERR_EN
    assign bus.step_err   = step_err_q;
    assign bus.err_sticky = sticky_q;
`else
    // Error logic is absent; outputs are tied off. clr_err has no effect.
    assign bus.step_err   = 1'b0;
    assign bus.err_sticky = 1'b0;
`endif

endmodule
